// File: rtl/mult4_digit_seq_ctrl.sv
// Sequential 4x4 unsigned multiplier that drives one shared external 2x2 core,
// one digit pair per cycle, and accumulates the shifted partial products.
module mult4_digit_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [1:0] mul_a,
    output logic [1:0] mul_b,
    output logic       mul_en,
    input  logic [3:0] mul_p,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] P,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic [3:0]  mask_q, mask_d;
    logic [7:0]  acc_q, acc_d;
    logic [3:0]  accept_mask;
    logic [3:0]  mask_cleared;
    logic [1:0]  step;
    logic [1:0]  shift_units;
    logic [7:0]  pp_shifted;

    // Step gi uses the high digit of A when gi>=2 and the high digit of B when gi is odd.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_step
            logic [1:0] da;
            logic [1:0] db;
            assign da = (gi >= 2) ? A[3:2] : A[1:0];
            assign db = ((gi % 2) == 1) ? B[3:2] : B[1:0];
            assign accept_mask[gi] = !SKIP_ZERO || ((da != 2'd0) && (db != 2'd0));
        end
    endgenerate

    always_comb begin
        step = 2'd0;
        if (mask_q[0])      step = 2'd0;
        else if (mask_q[1]) step = 2'd1;
        else if (mask_q[2]) step = 2'd2;
        else if (mask_q[3]) step = 2'd3;
    end

    assign mask_cleared = mask_q & (mask_q - 4'd1);
    // Shift is twice the number of high digits in the pair: 0, 2, 2, 4.
    assign shift_units  = {step[1] & step[0], step[1] ^ step[0]};
    assign pp_shifted   = {4'd0, mul_p} << {shift_units, 1'b0};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mask_d    = mask_q;
        acc_d     = acc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_en    = 1'b0;
        mul_a     = 2'd0;
        mul_b     = 2'd0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = 8'd0;
                    mask_d  = accept_mask;
                    state_d = (accept_mask != 4'd0) ? MUL : DONE;
                end
            end
            MUL: begin
                mul_en = 1'b1;
                mul_a  = step[1] ? a_q[3:2] : a_q[1:0];
                mul_b  = step[0] ? b_q[3:2] : b_q[1:0];
                acc_d  = acc_q + pp_shifted;
                mask_d = mask_cleared;
                if (mask_cleared == 4'd0) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            mask_q  <= 4'd0;
            acc_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mask_q  <= mask_d;
            acc_q   <= acc_d;
        end
    end

    assign P    = acc_q;
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_mult4_digit_seq_ctrl.sv
// Scoreboard bench for mult4_digit_seq_ctrl: one instance without and one with
// zero-digit skipping, both fed by a bench-side exact or approximate 2x2 core.
module tb_mult4_digit_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, out_ready, sel, approx;
    logic [3:0] A, B;
    logic       in_valid0, in_valid1;
    logic       in_ready0, in_ready1, mul_en0, mul_en1;
    logic       out_valid0, out_valid1, busy0, busy1;
    logic [1:0] mul_a0, mul_b0, mul_a1, mul_b1;
    logic [3:0] mul_p0, mul_p1;
    logic [7:0] P0, P1;

    int total = 0;
    int passed = 0;

    function automatic logic [3:0] core(input logic [1:0] a, input logic [1:0] b, input logic ap);
        if (ap && a == 2'd3 && b == 2'd3) return 4'd7;
        return {2'b00, a} * {2'b00, b};
    endfunction

    assign in_valid0 = in_valid & ~sel;
    assign in_valid1 = in_valid & sel;
    assign mul_p0    = core(mul_a0, mul_b0, approx);
    assign mul_p1    = core(mul_a1, mul_b1, approx);

    mult4_digit_seq_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .A(A), .B(B), .mul_a(mul_a0), .mul_b(mul_b0), .mul_en(mul_en0),
        .mul_p(mul_p0), .out_valid(out_valid0), .out_ready(out_ready),
        .P(P0), .busy(busy0));

    mult4_digit_seq_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(A), .B(B), .mul_a(mul_a1), .mul_b(mul_b1), .mul_en(mul_en1),
        .mul_p(mul_p1), .out_valid(out_valid1), .out_ready(out_ready),
        .P(P1), .busy(busy1));

    logic       in_ready_s, mul_en_s, out_valid_s, busy_s;
    logic [1:0] mul_a_s, mul_b_s;
    logic [7:0] P_s;
    assign in_ready_s  = sel ? in_ready1  : in_ready0;
    assign mul_en_s    = sel ? mul_en1    : mul_en0;
    assign out_valid_s = sel ? out_valid1 : out_valid0;
    assign busy_s      = sel ? busy1      : busy0;
    assign mul_a_s     = sel ? mul_a1     : mul_a0;
    assign mul_b_s     = sel ? mul_b1     : mul_b0;
    assign P_s         = sel ? P1         : P0;

    typedef struct {
        logic [7:0]  p;
        int          k;
        logic [15:0] pairs;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                   input logic skip, input logic ap);
        exp_t e;
        logic [1:0] da, db;
        int sh[4] = '{0, 2, 2, 4};
        e.p = 8'd0;
        e.k = 0;
        e.pairs = 16'd0;
        for (int s = 0; s < 4; s++) begin
            da = (s >= 2) ? a[3:2] : a[1:0];
            db = ((s % 2) == 1) ? b[3:2] : b[1:0];
            if (!skip || (da != 2'd0 && db != 2'd0)) begin
                e.p = e.p + 8'({4'd0, core(da, db, ap)} << sh[s]);
                e.pairs[4*e.k +: 4] = {da, db};
                e.k++;
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Monitor: tracks the in-flight operation and checks digits, latency and result.
    exp_t cur;
    int   cyc, en_cnt;
    bit   active = 1'b0, seen = 1'b0, check_ir = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            active   = 1'b0;
            check_ir = 1'b0;
        end else begin
            if (check_ir) begin
                chk("in_ready_after_out", in_ready_s, 1);
                chk("out_valid_drop", out_valid_s, 0);
                chk("busy_after_out", busy_s, 0);
                check_ir = 1'b0;
            end
            if (active) begin
                cyc++;
                if (mul_en_s) begin
                    if (en_cnt < cur.k) chk("mul_pair", {mul_a_s, mul_b_s}, cur.pairs[4*en_cnt +: 4]);
                    else chk("mul_en_extra", en_cnt + 1, cur.k);
                    en_cnt++;
                end else begin
                    chk("mul_idle_digits", {mul_a_s, mul_b_s}, 0);
                end
                if (out_valid_s && !seen) begin
                    seen = 1'b1;
                    chk("latency", cyc, cur.k + 1);
                    chk("mul_en_count", en_cnt, cur.k);
                    chk("busy_done", busy_s, 1);
                end
                if (out_valid_s && out_ready) begin
                    chk("P", P_s, cur.p);
                    $display("txn: P=%0d expected=%0d mul_steps=%0d latency=%0d", P_s, cur.p, en_cnt, cyc);
                    void'(exp_q.pop_front());
                    active   = 1'b0;
                    check_ir = 1'b1;
                end
            end
            if (in_valid && in_ready_s) begin
                if (exp_q.size() == 0) chk("unexpected_accept", 1, 0);
                else begin
                    cur    = exp_q[0];
                    active = 1'b1;
                    seen   = 1'b0;
                    cyc    = 0;
                    en_cnt = 0;
                end
            end
        end
    end

    task automatic wait_acc();
        int n = 0;
        @(negedge clk);
        while (!in_ready_s && n < 30) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready_s) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b);
        exp_q.push_back(model(a, b, sel, approx));
        A = a;
        B = b;
        in_valid = 1'b1;
        wait_acc();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || active) && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0 || active) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sel = 1'b0; approx = 1'b0; A = 4'd0; B = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_in_ready", in_ready_s, 1);
            chk("rst_out_valid", out_valid_s, 0);
            chk("rst_busy", busy_s, 0);
            chk("rst_mul_en", mul_en_s, 0);
            chk("rst_mul_digits", {mul_a_s, mul_b_s}, 0);
        end
        sel = 1'b0;
        @(posedge clk);
        #1;

        send(4'd15, 4'd15); drain();
        send(4'd13, 4'd11); drain();
        for (int i = 0; i < 6; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            drain();
        end

        // Backpressure with a new pair already waiting on the input.
        out_ready = 1'b0;
        send(4'd5, 4'd6);
        exp_q.push_back(model(4'd9, 4'd10, sel, approx));
        A = 4'd9; B = 4'd10; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!out_valid_s && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid_s) chk("bp_out_timeout", 0, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_P", P_s, 30);
            chk("bp_out_valid", out_valid_s, 1);
            chk("bp_in_ready", in_ready_s, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        wait_acc();
        out_ready = 1'b1;
        drain();

        // Reset in the second MUL cycle discards the operation.
        send(4'd7, 4'd9);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready_s, 1);
        chk("midrst_out_valid", out_valid_s, 0);
        chk("midrst_busy", busy_s, 0);
        chk("midrst_mul_digits", {mul_a_s, mul_b_s}, 0);
        @(posedge clk); #1;
        send(4'd2, 4'd3); drain();

        sel = 1'b1;
        #1;
        send(4'd3, 4'd4);  drain();
        send(4'd0, 4'd9);  drain();
        send(4'd15, 4'd15); drain();
        for (int i = 0; i < 6; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            drain();
        end

        sel = 1'b0;
        approx = 1'b1;
        #1;
        send(4'd15, 4'd15); drain();
        send(4'd14, 4'd11); drain();
        approx = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
